// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants plus the types used by the execute issue controller.
package riscv_pkg;

    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;

    typedef enum logic [0:0] {CTRL_RUN, CTRL_FLUSH} issue_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPCODE_REG_REG) || (opcode == OPCODE_BRANCH) ||
               (opcode == OPCODE_STORE);
    endfunction

    // The younger MEM result wins over WB when both write the same register.
    function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                              input logic       mem_we,
                                              input logic [4:0] mem_rd,
                                              input logic       wb_we,
                                              input logic [4:0] wb_rd);
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) return FWD_MEM;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))    return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_hazard_unit.sv
// Combinational load-use detection and ALU operand forwarding selects.
module ex_hazard_unit
    import riscv_pkg::*;
(
    input  logic       ex_valid,
    input  logic [6:0] ex_opcode,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       dec_valid,
    input  logic [6:0] dec_opcode,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic       load_use,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);

    logic ex_is_load;

    assign ex_is_load = ex_valid && (ex_opcode == OPCODE_LOAD) && (ex_rd != 5'd0);

    assign load_use = ex_is_load && dec_valid &&
                      ((dec_rs1 == ex_rd) || (uses_rs2(dec_opcode) && (dec_rs2 == ex_rd)));

    assign fwd_a_sel = ex_valid ? fwd_select(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd)
                                : FWD_RF;
    assign fwd_b_sel = ex_valid ? fwd_select(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd)
                                : FWD_RF;

endmodule

// File: rtl/execute_issue_ctrl.sv
// Execute-stage issue controller: owns the decode->execute register, inserts
// load-use bubbles and squashes wrong-path decode slots after a redirect.
module execute_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [6:0]       dec_opcode,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [6:0]       ex_opcode,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    input  logic             redirect,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    issue_state_e state;
    logic [2:0]   flush_cnt;
    logic         load_use;

    ex_hazard_unit u_hazard (
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .dec_valid    (dec_valid),
        .dec_opcode   (dec_opcode),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .load_use     (load_use),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
    );

    // FLUSH accepts everything so decode drains its wrong-path slots at full rate.
    assign dec_ready = !rst && ((state == CTRL_FLUSH) || (ex_ready && !load_use));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CTRL_RUN;
            flush_cnt   <= 3'd0;
            ex_valid    <= 1'b0;
            ex_opcode   <= 7'd0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            case (state)
                CTRL_RUN: begin
                    if (ex_ready) begin
                        if (redirect || load_use) begin
                            ex_valid  <= 1'b0;
                            ex_opcode <= 7'd0;
                            ex_rs1    <= 5'd0;
                            ex_rs2    <= 5'd0;
                            ex_rd     <= 5'd0;
                            if (redirect) begin
                                state     <= CTRL_FLUSH;
                                flush_cnt <= 3'(FLUSH_CYCLES);
                                if (flush_count != '1) flush_count <= flush_count + 1'b1;
                            end else if (stall_count != '1) begin
                                stall_count <= stall_count + 1'b1;
                            end
                        end else if (dec_valid) begin
                            ex_valid  <= 1'b1;
                            ex_opcode <= dec_opcode;
                            ex_rs1    <= dec_rs1;
                            ex_rs2    <= dec_rs2;
                            ex_rd     <= dec_rd;
                        end else begin
                            ex_valid <= 1'b0;
                        end
                    end
                end
                CTRL_FLUSH: begin
                    ex_valid  <= 1'b0;
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) state <= CTRL_RUN;
                end
                default: state <= CTRL_RUN;
            endcase
        end
    end

    a_no_redirect_in_flush: assert property (@(posedge clk) disable iff (rst)
        !((state == CTRL_FLUSH) && redirect));

endmodule

// File: tb/tb_execute_issue_ctrl.sv
// Scoreboard bench for execute_issue_ctrl: directed instruction sequences with
// hand-computed issue order and forwarding selects.
module tb_execute_issue_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        ex_ready, ex_valid;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        redirect;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_count, flush_count;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   waits;

    logic [4:0] pend_mem_rd, pend_wb_rd;
    logic       pend_mem_we, pend_wb_we;

    execute_issue_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_opcode   (dec_opcode),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .redirect     (redirect),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one decode instruction until it is accepted; returns the number of
    // cycles decode was held off. Leaves the bench at posedge+1 after the handshake.
    task automatic apply_stimulus(input logic [6:0] op, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic [1:0] fa, input logic [1:0] fb,
                                  output int stall_cycles);
        exp_t e;
        dec_valid    = 1'b1;
        dec_opcode   = op;
        dec_rs1      = rs1;
        dec_rs2      = rs2;
        dec_rd       = rd;
        stall_cycles = 0;
        @(negedge clk);
        while (!dec_ready && stall_cycles < 20) begin
            stall_cycles++;
            @(negedge clk);
        end
        if (!dec_ready) begin
            check_output("handshake_timeout", 32'(dec_ready), 32'd1);
        end else begin
            e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.fa = fa; e.fb = fb;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        dec_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // MEM/WB environment: an instruction leaving execute moves to MEM, then WB.
    initial begin
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_mem_rd = 5'd0; pend_mem_we = 1'b0; pend_wb_rd = 5'd0; pend_wb_we = 1'b0;
            end else if (ex_ready) begin
                pend_wb_rd  = mem_rd;
                pend_wb_we  = mem_regwrite;
                pend_mem_rd = ex_valid ? ex_rd : 5'd0;
                pend_mem_we = ex_valid && (ex_opcode != OPCODE_STORE) && (ex_opcode != OPCODE_BRANCH);
            end else begin
                pend_mem_rd = mem_rd; pend_mem_we = mem_regwrite;
                pend_wb_rd  = wb_rd;  pend_wb_we  = wb_regwrite;
            end
            @(posedge clk);
            mem_rd = pend_mem_rd; mem_regwrite = pend_mem_we;
            wb_rd  = pend_wb_rd;  wb_regwrite  = pend_wb_we;
        end
    end

    // Monitor: every instruction handed to MEM must be the oldest expected issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ex_valid && ex_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_issue_rd", 32'(ex_rd), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check_output("issue_opcode", 32'(ex_opcode), 32'(e.op));
                    check_output("issue_rs1",    32'(ex_rs1),    32'(e.rs1));
                    check_output("issue_rs2",    32'(ex_rs2),    32'(e.rs2));
                    check_output("issue_rd",     32'(ex_rd),     32'(e.rd));
                    check_output("issue_fwd_a",  32'(fwd_a_sel), 32'(e.fa));
                    check_output("issue_fwd_b",  32'(fwd_b_sel), 32'(e.fb));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; dec_valid = 1'b0; dec_opcode = 7'd0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
        dec_rd = 5'd0; ex_ready = 1'b1; redirect = 1'b0;
        #3;
        check_output("rst_ex_valid",    32'(ex_valid),    32'd0);
        check_output("rst_dec_ready",   32'(dec_ready),   32'd0);
        check_output("rst_stall_count", 32'(stall_count), 32'd0);
        check_output("rst_flush_count", 32'(flush_count), 32'd0);
        check_output("rst_fwd_a",       32'(fwd_a_sel),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // ADD x3,x1,x2 then ADD x4,x3,x3: x3 forwarded from MEM on both operands.
        apply_stimulus(OPCODE_REG_REG, 5'd1, 5'd2, 5'd3, 2'd0, 2'd0, waits);
        check_output("add_ex_valid", 32'(ex_valid), 32'd1);
        check_output("add_ex_rd",    32'(ex_rd),    32'd3);
        apply_stimulus(OPCODE_REG_REG, 5'd3, 5'd3, 5'd4, 2'd1, 2'd1, waits);
        check_output("add_no_stall", 32'(waits), 32'd0);
        idle(3);

        // LW x5 then ADD x6,x5,x0: one bubble, then WB forwarding.
        apply_stimulus(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 2'd0, 2'd0, waits);
        apply_stimulus(OPCODE_REG_REG, 5'd5, 5'd0, 5'd6, 2'd2, 2'd0, waits);
        check_output("lu_stall_cycles", 32'(waits), 32'd1);
        check_output("lu_stall_count",  32'(stall_count), 32'd1);
        idle(3);

        // LW x0 followed by a reader of x0: no hazard.
        apply_stimulus(OPCODE_LOAD, 5'd2, 5'd0, 5'd0, 2'd0, 2'd0, waits);
        apply_stimulus(OPCODE_REG_REG, 5'd0, 5'd0, 5'd7, 2'd0, 2'd0, waits);
        check_output("x0_no_stall",    32'(waits), 32'd0);
        check_output("x0_stall_count", 32'(stall_count), 32'd1);
        idle(3);

        // Redirect with decode held valid: three slots discarded, the fourth issues.
        apply_stimulus(OPCODE_BRANCH, 5'd1, 5'd2, 5'd0, 2'd0, 2'd0, waits);
        for (int k = 0; k < 4; k++) begin
            dec_valid  = 1'b1;
            dec_opcode = OPCODE_REG_REG;
            dec_rs1    = 5'd1;
            dec_rs2    = 5'd1;
            dec_rd     = 5'(8 + k);
            redirect   = (k == 0);
            @(negedge clk);
            check_output("flush_dec_ready", 32'(dec_ready), 32'd1);
            check_output("flush_ex_valid",  32'(ex_valid),  (k == 0) ? 32'd1 : 32'd0);
            if (k == 3) sb.push_back('{OPCODE_REG_REG, 5'd1, 5'd1, 5'd11, 2'd0, 2'd0});
            @(posedge clk); #1;
        end
        redirect  = 1'b0;
        dec_valid = 1'b0;
        check_output("flush_count_1",     32'(flush_count), 32'd1);
        check_output("flush_stall_count", 32'(stall_count), 32'd1);
        idle(3);

        // Load-use while ex_ready is low for 4 cycles: held, no count until released.
        apply_stimulus(OPCODE_LOAD, 5'd3, 5'd0, 5'd9, 2'd0, 2'd0, waits);
        ex_ready   = 1'b0;
        dec_valid  = 1'b1;
        dec_opcode = OPCODE_REG_REG;
        dec_rs1    = 5'd9;
        dec_rs2    = 5'd2;
        dec_rd     = 5'd10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("hold_dec_ready",   32'(dec_ready),   32'd0);
            check_output("hold_ex_rd",       32'(ex_rd),       32'd9);
            check_output("hold_stall_count", 32'(stall_count), 32'd1);
        end
        @(posedge clk); #1;
        ex_ready = 1'b1;
        apply_stimulus(OPCODE_REG_REG, 5'd9, 5'd2, 5'd10, 2'd2, 2'd0, waits);
        check_output("hold_release_stall", 32'(waits), 32'd1);
        check_output("hold_stall_count_2", 32'(stall_count), 32'd2);
        idle(3);

        // Reset pulsed mid-FLUSH (flush_cnt=2): immediate return to idle RUN.
        apply_stimulus(OPCODE_BRANCH, 5'd1, 5'd2, 5'd0, 2'd0, 2'd0, waits);
        redirect = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b0;
        check_output("midflush_ex_valid",  32'(ex_valid),  32'd0);
        check_output("midflush_dec_ready", 32'(dec_ready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_ex_valid",    32'(ex_valid),    32'd0);
        check_output("arst_dec_ready",   32'(dec_ready),   32'd0);
        check_output("arst_flush_count", 32'(flush_count), 32'd0);
        check_output("arst_stall_count", 32'(stall_count), 32'd0);
        check_output("arst_fwd_b",       32'(fwd_b_sel),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        apply_stimulus(OPCODE_REG_REG, 5'd1, 5'd2, 5'd12, 2'd0, 2'd0, waits);
        check_output("post_rst_no_discard", 32'(waits), 32'd0);
        check_output("post_rst_ex_rd",      32'(ex_rd), 32'd12);
        idle(4);

        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
